// File: rtl/aibndaux_pkg.sv
`default_nettype none
// ============================================================================
// Package  : aibndaux_pkg
// Brief    : Shared state encoding and default timing for the AIB aux POR
//            sequencer.
// Revision : 1.0
// ============================================================================
package aibndaux_pkg;

    localparam logic [1:0] c_st_idle     = 2'd0;
    localparam logic [1:0] c_st_debounce = 2'd1;
    localparam logic [1:0] c_st_hold     = 2'd2;
    localparam logic [1:0] c_st_run      = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE     = c_st_idle,
        ST_DEBOUNCE = c_st_debounce,
        ST_HOLD     = c_st_hold,
        ST_RUN      = c_st_run
    } state_e;

    localparam int c_deb_cyc_def  = 16;
    localparam int c_hold_cyc_def = 64;
    localparam int c_cnt_w_def    = 8;

endpackage
`default_nettype wire

// File: rtl/aibndaux_sync2.sv
`default_nettype none
// ============================================================================
// Module   : aibndaux_sync2
// Brief    : Two-flop synchronizer with asynchronous active-low reset.
// Revision : 1.0
// ============================================================================
module aibndaux_sync2 (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/aibndaux_por_seq.sv
`default_nettype none
// ============================================================================
// Module   : aibndaux_por_seq
// Brief    : Die-connection debounce and peer power-on-reset sequencer for the
//            AIB aux channel.
// Revision : 1.0
// ============================================================================
module aibndaux_por_seq
    import aibndaux_pkg::*;
#(
    parameter int DEB_CYC  = c_deb_cyc_def,
    parameter int HOLD_CYC = c_hold_cyc_def,
    parameter int CNT_W    = c_cnt_w_def
) (
    input  logic       i_osc_clk,
    input  logic       i_por_rst_n,
    input  logic       i_crdet,
    input  logic       i_sw_por,
    input  logic       i_crdet_ovrd_en,
    output logic       o_dn_por,
    output logic       o_crdet_ovrd,
    output logic       o_link_up,
    output logic [1:0] o_state,
    output logic       o_lost_pulse
);

    localparam logic [CNT_W-1:0] c_deb_last  = CNT_W'(DEB_CYC - 1);
    localparam logic [CNT_W-1:0] c_hold_last = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] c_cnt_max   = {CNT_W{1'b1}};

    logic             w_crdet_s;
    logic             w_crdet_q;
    logic             w_lost;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [CNT_W-1:0] w_nxt_cnt;
    state_e           w_nxt_state;

    state_e           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_dn_por;
    logic             r_link_up;
    logic             r_lost_pulse;
    logic             r_crdet_ovrd;

    aibndaux_sync2 u_sync (
        .i_clk   (i_osc_clk),
        .i_rst_n (i_por_rst_n),
        .i_d     (i_crdet),
        .o_q     (w_crdet_s)
    );

    assign w_crdet_q = w_crdet_s | r_crdet_ovrd;
    assign w_cnt_inc = (r_cnt == c_cnt_max) ? r_cnt : r_cnt + CNT_W'(1);

    // Loss of crdet outranks a software re-reset, which outranks count expiry.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_cnt   = '0;
        w_lost      = 1'b0;
        if (!w_crdet_q) begin
            w_nxt_state = ST_IDLE;
            w_lost      = (r_state == ST_RUN);
        end else if (i_sw_por) begin
            w_nxt_state = ST_HOLD;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_nxt_state = ST_DEBOUNCE;
                end
                ST_DEBOUNCE: begin
                    if (r_crdet_ovrd || (r_cnt == c_deb_last)) begin
                        w_nxt_state = ST_HOLD;
                    end else begin
                        w_nxt_cnt = w_cnt_inc;
                    end
                end
                ST_HOLD: begin
                    if (r_cnt == c_hold_last) begin
                        w_nxt_state = ST_RUN;
                    end else begin
                        w_nxt_cnt = w_cnt_inc;
                    end
                end
                ST_RUN: begin
                    w_nxt_state = ST_RUN;
                end
                default: begin
                    w_nxt_state = ST_IDLE;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they line up with r_state.
    always_ff @(posedge i_osc_clk or negedge i_por_rst_n) begin
        if (!i_por_rst_n) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_dn_por     <= 1'b1;
            r_link_up    <= 1'b0;
            r_lost_pulse <= 1'b0;
            r_crdet_ovrd <= 1'b0;
        end else begin
            r_state      <= w_nxt_state;
            r_cnt        <= w_nxt_cnt;
            r_dn_por     <= (w_nxt_state != ST_RUN);
            r_link_up    <= (w_nxt_state == ST_RUN);
            r_lost_pulse <= w_lost;
            r_crdet_ovrd <= i_crdet_ovrd_en;
        end
    end

    assign o_dn_por     = r_dn_por;
    assign o_crdet_ovrd = r_crdet_ovrd;
    assign o_link_up    = r_link_up;
    assign o_state      = r_state;
    assign o_lost_pulse = r_lost_pulse;

endmodule
`default_nettype wire

// File: tb/tb_aibndaux_por_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_aibndaux_por_seq
// Brief    : Directed and randomized bench for aibndaux_por_seq with a
//            behavioural reference model.
// Revision : 1.0
// ============================================================================
module tb_aibndaux_por_seq;

    localparam int DEB  = 16;
    localparam int HOLD = 64;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       crdet;
    logic       sw_por;
    logic       ovrd_en;
    logic       dn_por;
    logic       crdet_ovrd;
    logic       link_up;
    logic [1:0] state;
    logic       lost_pulse;

    int checks = 0;
    int errors = 0;

    // Reference model: phase 0..3 = idle/debounce/hold/run, n = cycles counted
    int m_ph;
    int m_n;
    bit m_pipe [2];
    bit m_ovrd;
    bit m_lost;

    always #5 clk = ~clk;

    aibndaux_por_seq #(
        .DEB_CYC  (DEB),
        .HOLD_CYC (HOLD),
        .CNT_W    (8)
    ) dut (
        .i_osc_clk       (clk),
        .i_por_rst_n     (rst_n),
        .i_crdet         (crdet),
        .i_sw_por        (sw_por),
        .i_crdet_ovrd_en (ovrd_en),
        .o_dn_por        (dn_por),
        .o_crdet_ovrd    (crdet_ovrd),
        .o_link_up       (link_up),
        .o_state         (state),
        .o_lost_pulse    (lost_pulse)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_ph      = 0;
        m_n       = 0;
        m_pipe[0] = 1'b0;
        m_pipe[1] = 1'b0;
        m_ovrd    = 1'b0;
        m_lost    = 1'b0;
    endfunction

    function automatic void model_clock();
        bit present;
        present = m_pipe[1] | m_ovrd;
        m_lost  = 1'b0;
        if (!present) begin
            m_lost = (m_ph == 3);
            m_ph   = 0;
            m_n    = 0;
        end else if (sw_por) begin
            m_ph = 2;
            m_n  = 0;
        end else if (m_ph == 0) begin
            m_ph = 1;
            m_n  = 0;
        end else if (m_ph == 1) begin
            m_n++;
            if (m_ovrd || m_n >= DEB) begin
                m_ph = 2;
                m_n  = 0;
            end
        end else if (m_ph == 2) begin
            m_n++;
            if (m_n >= HOLD) begin
                m_ph = 3;
                m_n  = 0;
            end
        end
        m_pipe[1] = m_pipe[0];
        m_pipe[0] = crdet;
        m_ovrd    = ovrd_en;
    endfunction

    task automatic check_model();
        chk("state",      32'(state),      32'(m_ph));
        chk("dn_por",     32'(dn_por),     32'(m_ph != 3));
        chk("link_up",    32'(link_up),    32'(m_ph == 3));
        chk("lost_pulse", 32'(lost_pulse), 32'(m_lost));
        chk("crdet_ovrd", 32'(crdet_ovrd), 32'(m_ovrd));
    endtask

    task automatic step();
        @(posedge clk);
        model_clock();
        @(negedge clk);
        check_model();
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_state"},      32'(state),      32'd0);
        chk({tag, "_dn_por"},     32'(dn_por),     32'd1);
        chk({tag, "_link_up"},    32'(link_up),    32'd0);
        chk({tag, "_lost_pulse"}, 32'(lost_pulse), 32'd0);
        chk({tag, "_crdet_ovrd"}, 32'(crdet_ovrd), 32'd0);
    endtask

    initial begin
        int n;
        int pulses;
        bit seen_link;
        bit seen_dn_low;

        rst_n   = 1'b0;
        crdet   = 1'b0;
        sw_por  = 1'b0;
        ovrd_en = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_values("reset");

        rst_n = 1'b1;
        repeat (4) step();

        // Stable crdet: o_dn_por falls 2 + 1 + DEB + HOLD edges after the rise
        crdet = 1'b1;
        n = 0;
        while (dn_por && n < 300) begin
            step();
            n++;
        end
        chk("crdet_to_run_latency", 32'(n), 32'(2 + 1 + DEB + HOLD));
        chk("run_link_up", 32'(link_up), 32'd1);
        repeat (5) step();

        // Loss of crdet in RUN
        crdet  = 1'b0;
        pulses = 0;
        repeat (3) begin
            step();
            pulses += int'(lost_pulse);
        end
        chk("loss_dn_por", 32'(dn_por), 32'd1);
        chk("loss_state",  32'(state),  32'd0);
        repeat (4) begin
            step();
            pulses += int'(lost_pulse);
        end
        chk("loss_pulse_count", 32'(pulses), 32'd1);

        // Short glitch never qualifies
        seen_link   = 1'b0;
        seen_dn_low = 1'b0;
        crdet = 1'b1;
        repeat (10) begin
            step();
            seen_link   |= link_up;
            seen_dn_low |= ~dn_por;
        end
        crdet = 1'b0;
        repeat (20) begin
            step();
            seen_link   |= link_up;
            seen_dn_low |= ~dn_por;
        end
        chk("glitch_link_up", 32'(seen_link),   32'd0);
        chk("glitch_dn_low",  32'(seen_dn_low), 32'd0);
        chk("glitch_state",   32'(state),       32'd0);

        // Software re-reset from RUN for 5 cycles
        crdet = 1'b1;
        n = 0;
        while (!link_up && n < 300) begin
            step();
            n++;
        end
        chk("sw_setup_run", 32'(link_up), 32'd1);
        sw_por = 1'b1;
        n = 0;
        repeat (5) begin
            step();
            n++;
        end
        chk("sw_por_dn_por", 32'(dn_por), 32'd1);
        chk("sw_por_state",  32'(state),  32'd2);
        sw_por = 1'b0;
        while (dn_por && n < 300) begin
            step();
            n++;
        end
        chk("sw_por_to_run", 32'(n), 32'(5 + HOLD));

        // Randomized segments against the model
        for (int seg = 0; seg < 60; seg++) begin
            int len;
            len     = int'($urandom_range(1, 120));
            crdet   = ($urandom_range(0, 3) != 0);
            ovrd_en = ($urandom_range(0, 7) == 0);
            for (int c = 0; c < len; c++) begin
                sw_por = ($urandom_range(0, 63) == 0);
                step();
            end
        end
        sw_por  = 1'b0;
        ovrd_en = 1'b0;
        crdet   = 1'b0;

        // Override path from a fresh reset, then async reset mid-HOLD
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        model_reset();
        rst_n   = 1'b1;
        ovrd_en = 1'b1;
        step();
        chk("ovrd_registered", 32'(crdet_ovrd), 32'd1);
        n = 0;
        while (!link_up && n < 300) begin
            step();
            n++;
        end
        chk("ovrd_to_run", 32'(n), 32'(1 + 1 + HOLD));
        sw_por = 1'b1;
        step();
        sw_por = 1'b0;
        repeat (20) step();
        chk("pre_reset_state", 32'(state), 32'd2);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("async_reset");
        model_reset();
        @(negedge clk);
        rst_n   = 1'b1;
        ovrd_en = 1'b0;
        repeat (3) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
